// File: rtl/cam_capture_rgb444.sv
`default_nettype none
// ============================================================================
// Module : cam_capture_rgb444
// Brief  : OV7670 RGB565 byte-pair capture, converted to RGB444 writes into
//          a linear frame-buffer write port (camera pixel-clock domain).
// Rev    : 1.0
// ============================================================================
module cam_capture_rgb444 #(
  parameter int AW    = 15,
  parameter int DW    = 12,
  parameter int H_RES = 160,
  parameter int V_RES = 120
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr,
  output logic          frame_done,
  output logic          frame_err,
  output logic          busy
);

  localparam int            CW     = AW + 1;
  localparam logic [CW-1:0] C_NPIX = CW'(H_RES * V_RES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BYTE_HI = 2'd1,
    BYTE_LO = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          vsync_q;
  logic          armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    hi_q, hi_d;
  logic          err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          wr_q, wr_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;
  logic          frame_start;
  logic          frame_end;

  // vsync_q comes out of reset high, so a release in the middle of an active
  // frame would look like a falling edge; armed_q requires real blanking first.
  always_comb begin
    frame_start = vsync_q & ~vsync & armed_q;
    frame_end   = ~vsync_q & vsync;
    state_d     = state_q;
    armed_d     = armed_q | vsync;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    err_d       = err_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wr_d        = 1'b0;
    done_d      = 1'b0;
    ferr_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_start && enable) begin
          state_d = BYTE_HI;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      BYTE_HI, BYTE_LO: begin
        if (frame_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
          ferr_d  = err_q | (cnt_q != C_NPIX);
        end else if (state_q == BYTE_HI) begin
          if (href) begin
            hi_d    = {px_data[7:4], px_data[2:0]};
            state_d = BYTE_LO;
          end
        end else begin
          state_d = BYTE_HI;
          if (!href) begin
            err_d = 1'b1;
          end else if (cnt_q < C_NPIX) begin
            wr_d   = 1'b1;
            addr_d = cnt_q[AW-1:0];
            data_d = DW'({hi_q, px_data[7], px_data[4:1]});
            cnt_d  = cnt_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      vsync_q <= 1'b1;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= vsync;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign mem_px_addr = addr_q;
  assign mem_px_data = data_q;
  assign px_wr       = wr_q;
  assign frame_done  = done_q;
  assign frame_err   = ferr_q;
  assign busy        = (state_q != IDLE);

endmodule
`default_nettype wire

// File: doc/cam_capture_rgb444.md
Name: cam_capture_rgb444

Overview:
- Upstream stage of the dual-port frame buffer: samples the OV7670 parallel bus (RGB565, two bytes per pixel) and converts each pixel to RGB444.
- Produces the linear write address, write data and write strobe for the buffer's write port.
- Runs entirely in the camera pixel-clock domain; the buffer's read side (VGA) is independent.

Parameters:
- AW, 15, write-address width; must satisfy 2^AW >= H_RES*V_RES.
- DW, 12, pixel width out (RGB444, {R[3:0],G[3:0],B[3:0]}).
- H_RES, 160, pixels per line.
- V_RES, 120, lines per frame.

Ports:
- clk  in  1  camera pixel clock (PCLK); all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  capture permitted (camera init done); sampled only at frame start.
- vsync  in  1  camera VSYNC, high = vertical blanking.
- href  in  1  camera HREF, high = valid byte on px_data.
- px_data  in  8  camera data byte.
- mem_px_addr  out  AW  buffer write address.
- mem_px_data  out  DW  buffer write data.
- px_wr  out  1  buffer write enable, one cycle per pixel.
- frame_done  out  1  one-cycle pulse at end of a captured frame.
- frame_err  out  1  valid with frame_done: pixel count != H_RES*V_RES, or an odd byte count on some line.
- busy  out  1  high while in CAPTURE states.

Behaviour:
- Reset (reset=0, async): all outputs 0, state IDLE, pixel counter 0, vsync_q 1, error flag 0.
- vsync_q is vsync registered once. Frame start = vsync_q=1 and vsync=0 (falling). Frame end = vsync_q=0 and vsync=1 (rising).
- States:
  - IDLE: wait for a frame start with enable=1, then go to BYTE_HI. Clear the pixel counter and error flag; busy=1 from the next cycle. enable=0 at frame start keeps the block in IDLE for that whole frame.
  - BYTE_HI: on an edge with href=1, latch hi<=px_data and go to BYTE_LO.
  - BYTE_LO, href=1 on the edge: register the pixel.
    - mem_px_data <= {hi[7:4], hi[2:0], px_data[7], px_data[4:1]}.
    - mem_px_addr <= pixel counter.
    - px_wr <= 1, if counter < H_RES*V_RES; otherwise no write and error flag set.
    - Counter increments, saturating at H_RES*V_RES.
    - Return to BYTE_HI.
  - BYTE_LO, href=0 on the edge: the half pixel is discarded, error flag set, return to BYTE_HI.
  - Frame end in BYTE_HI or BYTE_LO: go to IDLE. In the same edge, frame_done <= 1 and frame_err <= (error flag | counter != H_RES*V_RES). busy <= 0.
- Latency: byte 2 sampled at edge N. Address and data are stable and px_wr=1 during cycle N..N+1, so the buffer captures at edge N+1.
- px_wr is a single-cycle pulse. Its minimum spacing is 2 cycles. mem_px_addr and mem_px_data hold their last values between writes.
- frame_done and frame_err are 1 for exactly one cycle, then return to 0.
- href is ignored while vsync=1, and in IDLE.
- The byte phase does not carry across lines: when href falls, any pending high byte is dropped (see BYTE_LO, href=0).
- A frame end and an href-qualified byte on the same edge: the frame end wins and the byte is not written.
- A frame end while in IDLE: no pulse.
- A frame start arriving while busy is impossible without a frame end first; the frame end is always handled first.
- Reset mid-frame: immediate return to IDLE. Capture resumes only at the next frame start after reset is released.
- Addresses never wrap. The maximum written address is H_RES*V_RES-1 (19199 by default).

Test Plan:
- Nominal frame: enable=1, vsync fall, 120 lines of 320 bytes each, byte pair 0xF8,0x1F on every pixel, then vsync rise.
  - Required: 19200 px_wr pulses, addresses 0..19199 in order, data 0xF0F each.
  - One frame_done pulse with frame_err=0.
- Colour mapping: pixel bytes 0x07,0xE0 -> data 0x0F0. Pixel bytes 0x00,0x1E -> data 0x00F.
  - Each write occurs on the cycle after the second byte is sampled.
- Odd line: line 5 carries 319 bytes.
  - Required: line 5 writes 159 pixels; the next line's first byte is treated as a high byte.
  - frame_done with frame_err=1.
- Overflow: 121 lines of 320 bytes.
  - Required: no px_wr beyond address 19199; frame_err=1 at frame end.
- Disabled and reset:
  - enable=0 at vsync fall -> no px_wr and no frame_done for that frame.
  - Next frame with enable=1 -> normal capture from address 0.
  - reset=0 pulsed mid-line -> outputs 0 immediately; capture restarts only after the following vsync fall.
- Collision: vsync rises on the same edge as a second byte.
  - Required: that pixel is not written; frame_done pulses; busy=0 the following cycle.
